// File: rtl/readback_line_sequencer.sv
// Line sequencer for the DDR readback buffer: one burst request per line, drains the line
// into a small output FIFO and streams it out. Optional starvation timeout: READBACK_SEQ_TIMEOUT_EN.
module readback_line_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned MEM_DATA_BITS  = 256,
    parameter int unsigned BURST_LEN      = 128,
    parameter int unsigned LINE_GAP       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  ddr_clk_i,
    input  logic                  ddr_rst_n_i,
    input  logic                  start_i,
    input  logic [31:0]           start_line_i,
    input  logic [15:0]           line_num_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  burst_flag_o,
    output logic [31:0]           burst_line_o,
    input  logic                  ddr_fifo_empty_i,
    output logic                  ddr_fifo_rd_en_o,
    input  logic                  ddr_fifo_rd_vld_i,
    input  logic [DATA_WIDTH-1:0] ddr_fifo_rd_data_i,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic [DATA_WIDTH-1:0] m_tdata_o,
    output logic                  m_tlast_o
);

    localparam int unsigned LINE_WORDS = BURST_LEN * MEM_DATA_BITS / DATA_WIDTH;
    localparam int unsigned CNT_W      = $clog2(LINE_WORDS + 1);
    localparam logic [CNT_W-1:0] LINE_WORDS_C = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(LINE_WORDS - 1);
    // GAP lasts LINE_GAP-1 cycles; with the registered request that leaves LINE_GAP idle cycles
    localparam logic [15:0]      GAP_LAST     = 16'(LINE_GAP - 2);

    if (LINE_GAP < 2 || TIMEOUT_CYCLES > 65535 || LINE_WORDS < 2) begin : g_param_check
        $error("readback_line_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN,
        S_GAP,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]           cur_line;
    logic [15:0]           lines_left;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      received;
    logic [15:0]           gap_cnt;
    logic                  inflight;
    logic [2:0]            occ;
    logic [2:0]            occ_pend;
    logic                  room_ok;
    logic [DATA_WIDTH:0]   fifo_mem [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic                  rd_en;
    logic                  push;
    logic                  pop;
    logic                  last_word;
    logic                  gap_done;
    logic                  timeout;
    logic                  burst_flag_q;
    logic [31:0]           burst_line_q;

    assign occ_pend  = occ + {2'b00, inflight};
    assign room_ok   = (occ_pend < 3'd3);
    assign last_word = (state == S_DRAIN) && ddr_fifo_rd_vld_i && (received == LAST_IDX);
    assign push      = ddr_fifo_rd_vld_i && ((state == S_DRAIN) || (state == S_FLUSH));
    assign pop       = (occ != 3'd0) && m_tready_i;
    assign gap_done  = (gap_cnt == GAP_LAST);

`ifdef READBACK_SEQ_TIMEOUT_EN
    logic [15:0] starve_cnt;
    logic        err_q;

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            starve_cnt <= '0;
        end else if (state != S_DRAIN || ddr_fifo_rd_vld_i) begin
            starve_cnt <= '0;
        end else if (ddr_fifo_empty_i && room_ok) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign timeout = (state == S_DRAIN) && (starve_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            // an empty frame passes through FLUSH so done lands two cycles after start
            S_IDLE:  if (start_i) state_nxt = (line_num_i == 16'd0) ? S_FLUSH : S_REQ;
            S_REQ:   state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (last_word) begin
                    state_nxt = (lines_left == 16'd1) ? S_FLUSH : S_GAP;
                end else if (timeout) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_GAP:   if (gap_done) state_nxt = S_REQ;
            S_FLUSH: if (occ == 3'd0 && !inflight) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != S_IDLE);
        done_o = (state == S_DONE);
        rd_en  = (state == S_DRAIN) && !ddr_fifo_empty_i && (issued < LINE_WORDS_C) && room_ok;
    end

    assign ddr_fifo_rd_en_o = rd_en;
    assign burst_flag_o     = burst_flag_q;
    assign burst_line_o     = burst_line_q;

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            cur_line     <= '0;
            lines_left   <= '0;
            issued       <= '0;
            received     <= '0;
            gap_cnt      <= '0;
            inflight     <= 1'b0;
            burst_flag_q <= 1'b0;
            burst_line_q <= '0;
        end else begin
            inflight     <= rd_en;
            burst_flag_q <= (state == S_REQ);
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cur_line   <= start_line_i;
                        lines_left <= line_num_i;
                    end
                end
                S_REQ: begin
                    burst_line_q <= cur_line;
                    issued       <= '0;
                    received     <= '0;
                end
                S_DRAIN: begin
                    gap_cnt <= '0;
                    if (rd_en) issued <= issued + 1'b1;
                    if (ddr_fifo_rd_vld_i) received <= received + 1'b1;
                    if (last_word) lines_left <= lines_left - 1'b1;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_done) cur_line <= cur_line + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output FIFO: entries hold {last, data}; occupancy is kept to 3 by the read throttle
    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {last_word, ddr_fifo_rd_data_i};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign m_tvalid_o = (occ != 3'd0);
    assign m_tdata_o  = fifo_mem[rd_ptr][DATA_WIDTH-1:0];
    assign m_tlast_o  = fifo_mem[rd_ptr][DATA_WIDTH];

endmodule
